// File: rtl/mel_pkg.sv
// ---------------------------------------------------------------------------
// mel_pkg
// Definitions shared by the mel front end: mel_filter, mel_log_compress and
// the DCT stage.
//   OUT_FRAC_BITS / OUT_INT_BITS : Q4.12 log2 output format
//   NUM_FILTERS_DEFAULT          : mel bands per frame
//   LOG_LUT                      : round(4096*log2(1+i/32)), i = 0..32
//   sat_frac()                   : clamps a 13-bit fraction to 12 bits
// ---------------------------------------------------------------------------
package mel_pkg;

    localparam int OUT_FRAC_BITS       = 12;
    localparam int OUT_INT_BITS        = 4;
    localparam int NUM_FILTERS_DEFAULT = 8;
    localparam int LOG_LUT_SIZE        = 33;

    // Entry 32 equals 4096 (log2(2) = 1.0), so 13 bits are needed. It is
    // only reached as the upper interpolation point.
    localparam logic [OUT_FRAC_BITS:0] LOG_LUT [LOG_LUT_SIZE] = '{
        13'd0,    13'd182,  13'd358,  13'd530,  13'd696,  13'd858,
        13'd1016, 13'd1169, 13'd1319, 13'd1465, 13'd1607, 13'd1746,
        13'd1882, 13'd2015, 13'd2145, 13'd2272, 13'd2396, 13'd2518,
        13'd2637, 13'd2754, 13'd2869, 13'd2982, 13'd3092, 13'd3200,
        13'd3307, 13'd3412, 13'd3514, 13'd3615, 13'd3715, 13'd3812,
        13'd3908, 13'd4003, 13'd4096
    };

    // A fraction of exactly 1.0 does not fit in the 12-bit field and would
    // otherwise roll into the integer part, so it is pinned to 0xFFF.
    function automatic logic [OUT_FRAC_BITS-1:0] sat_frac(
        input logic [OUT_FRAC_BITS:0] v
    );
        return v[OUT_FRAC_BITS] ? '1 : v[OUT_FRAC_BITS-1:0];
    endfunction

endpackage

// File: rtl/lzc16.sv
// ---------------------------------------------------------------------------
// lzc16
// Combinational leading-one detector for a 16-bit word.
//   din      : input word
//   pos      : index (0..15) of the most significant set bit; 0 when din = 0
//   all_zero : din is zero
// ---------------------------------------------------------------------------
module lzc16 (
    input  logic [15:0] din,
    output logic [3:0]  pos,
    output logic        all_zero
);

    // Scan upward so that the highest set bit wins.
    always_comb begin
        pos = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (din[i]) begin
                pos = 4'(i);
            end
        end
    end

    assign all_zero = (din == 16'd0);

endmodule

// File: rtl/mel_log_compress.sv
// ---------------------------------------------------------------------------
// mel_log_compress
// Converts mel band energies into Q4.12 log2 values through a three-stage
// pipeline:
//   S1 capture + leading-one detect
//   S2 normalise + LUT
//   S3 output register
// The latency is three cycles. One sample per cycle is accepted while the
// output is being taken. When the output is stalled, the whole pipeline holds.
//
// Parameters:
//   NUM_FILTERS : bands per frame; sets the out_last spacing
//   DATA_WIDTH  : mel_in width; must be 16 in this revision
//   OUT_WIDTH   : log_out width (Q4.12)
//
// Ports:
//   clk, rst  : clock; asynchronous active-high reset
//   mel_in    : unsigned band energy
//   in_valid  : mel_in is valid
//   in_ready  : mel_in is accepted this cycle
//   log_out   : log2(mel_in) in Q4.12; 0 when the input was zero
//   zero_flag : the input was zero
//   out_last  : this output is the last band of a frame
//   out_valid : the outputs are valid
//   out_ready : downstream accepts the output
//
// Build option:
//   MEL_LOG_INTERP_EN : when defined, interpolates linearly between adjacent
//                       LUT entries. When undefined, uses the LUT entry only,
//                       and no multiplier is built.
// ---------------------------------------------------------------------------
module mel_log_compress
    import mel_pkg::*;
#(
    parameter int NUM_FILTERS = NUM_FILTERS_DEFAULT,
    parameter int DATA_WIDTH  = 16,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] mel_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [OUT_WIDTH-1:0]  log_out,
    output logic                  zero_flag,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int                CNT_W     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BAND = CNT_W'(NUM_FILTERS - 1);

    // A single global enable: every stage moves unless a valid output is
    // being refused. Stages therefore never get out of step, and in_ready
    // equals the same enable.
    logic advance;
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    // ---------------- S1: capture + leading-one detect ----------------
    logic [3:0]  lz_pos;
    logic        lz_zero;
    logic        s1_valid;
    logic        s1_zero;
    logic [3:0]  s1_p;
    logic [15:0] s1_data;

    lzc16 u_lzc (
        .din      (mel_in),
        .pos      (lz_pos),
        .all_zero (lz_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_p     <= 4'd0;
            s1_data  <= 16'd0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_zero  <= lz_zero;
                s1_p     <= lz_pos;
                s1_data  <= mel_in;
            end
        end
    end

    // ---------------- S2: normalise + LUT ----------------
    // After normalisation the leading one sits at bit 15. The next five
    // bits select a LUT segment, and the remaining ten bits give the
    // position inside that segment.
    logic [15:0]            norm;
    logic [5:0]             idx;
    logic [OUT_FRAC_BITS:0] frac13;
`ifdef MEL_LOG_INTERP_EN
    logic [OUT_FRAC_BITS:0] seg_diff;
    logic [9:0]             seg_pos;
    logic [22:0]            seg_prod;
`endif

    always_comb begin
        norm = s1_data << (4'd15 - s1_p);
        idx  = {1'b0, 5'(norm >> 10)};
`ifdef MEL_LOG_INTERP_EN
        seg_pos  = 10'(norm);
        seg_diff = LOG_LUT[idx + 6'd1] - LOG_LUT[idx];
        seg_prod = {10'd0, seg_diff} * {13'd0, seg_pos};
        frac13   = LOG_LUT[idx] + 13'(seg_prod >> 10);
`else
        frac13   = LOG_LUT[idx];
`endif
    end

    logic                     s2_valid;
    logic                     s2_zero;
    logic [3:0]               s2_p;
    logic [OUT_FRAC_BITS-1:0] s2_frac;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_zero  <= 1'b0;
            s2_p     <= 4'd0;
            s2_frac  <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_zero <= s1_zero;
                s2_p    <= s1_zero ? 4'd0 : s1_p;
                s2_frac <= s1_zero ? '0 : sat_frac(frac13);
            end
        end
    end

    // ---------------- S3: output register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            log_out   <= '0;
            zero_flag <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                log_out   <= OUT_WIDTH'({s2_p, s2_frac});
                zero_flag <= s2_zero;
            end
        end
    end

    // The band counter moves only on accepted outputs. Stalls and bubbles
    // leave it untouched.
    logic [CNT_W-1:0] band_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            band_cnt <= '0;
        end else if (out_valid && out_ready) begin
            band_cnt <= (band_cnt == LAST_BAND) ? '0 : band_cnt + CNT_W'(1);
        end
    end

    assign out_last = out_valid && (band_cnt == LAST_BAND);

endmodule

// File: tb/tb_mel_log_compress.sv
// ---------------------------------------------------------------------------
// tb_mel_log_compress
// Self-checking bench for mel_log_compress. A reference model computes the
// expected log2 value from real-valued logarithms. Expected outputs are held
// in a queue in input order and checked as each output is accepted.
// Build option: MEL_LOG_INTERP_EN selects the interpolated reference and
// enables the accuracy bound.
// ---------------------------------------------------------------------------
module tb_mel_log_compress;

    localparam int NF = 8;

    logic        clk;
    logic        rst;
    logic [15:0] mel_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] log_out;
    logic        zero_flag;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    mel_log_compress #(
        .NUM_FILTERS (NF),
        .DATA_WIDTH  (16),
        .OUT_WIDTH   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mel_in    (mel_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .log_out   (log_out),
        .zero_flag (zero_flag),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] x;
        logic        zero;
        logic [15:0] log;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   out_cnt = 0;
    exp_t exp_q[$];

    logic        obs_in_fire, obs_out_fire, obs_in_ready, obs_valid, obs_out_ready;
    logic        obs_zero, obs_last;
    logic [15:0] obs_log;

    // Reference: 4096*log2(1+i/32), rounded to nearest.
    function automatic int lut_ref(int i);
        real v;
        v = 4096.0 * $ln(1.0 + real'(i) / 32.0) / $ln(2.0);
        return $rtoi(v + 0.5);
    endfunction

    // Reference: Q4.12 log2 of x. The integer part is the position of the
    // highest set bit; the fraction comes from the table segment selected by
    // the normalised mantissa.
    function automatic exp_t model(int x);
        exp_t r;
        int p, f, idx, rem, frac;
        r.x = 16'(x);
        if (x == 0) begin
            r.zero = 1'b1;
            r.log  = 16'h0000;
            return r;
        end
        p = 0;
        while ((x >> (p + 1)) != 0) p++;
        f   = (x << (15 - p)) - 32768;
        idx = f / 1024;
        rem = f % 1024;
`ifdef MEL_LOG_INTERP_EN
        frac = lut_ref(idx) + ((lut_ref(idx + 1) - lut_ref(idx)) * rem) / 1024;
`else
        frac = lut_ref(idx);
        if (rem < 0) frac = 0;
`endif
        if (frac > 4095) frac = 4095;
        r.zero = 1'b0;
        r.log  = 16'(p * 4096 + frac);
        return r;
    endfunction

    // Advances one cycle. Inputs are already set at posedge+1. At the
    // negedge the task records what will transfer at the coming edge and
    // queues the expected result of any accepted input.
    task automatic tick();
        @(negedge clk);
        obs_in_ready  = in_ready;
        obs_valid     = out_valid;
        obs_out_ready = out_ready;
        obs_in_fire   = in_valid && in_ready;
        obs_out_fire  = out_valid && out_ready;
        obs_log       = log_out;
        obs_zero      = zero_flag;
        obs_last      = out_last;
        if (obs_in_fire) exp_q.push_back(model(int'(mel_in)));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mel_in    = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        out_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        in_valid  = 1'b1;
        mel_in    = 16'h1234;
        out_ready = 1'b0;
        repeat (4) tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (log_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_log_out got %h exp 0000", log_out); end
        checks++; if (zero_flag !== 1'b0)   begin errors++; $display("[TB] FAIL reset_zero_flag got %b exp 0", zero_flag); end
        checks++; if (out_last !== 1'b0)    begin errors++; $display("[TB] FAIL reset_out_last got %b exp 0", out_last); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        out_cnt = 0;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_basic();
        int          vals [3] = '{1, 2, 32768};
        logic [15:0] exps [3] = '{16'h0000, 16'h1000, 16'hF000};
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mel_in    = 16'(vals[0]);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (k < 2) mel_in = 16'(vals[k + 1]);
            else       in_valid = 1'b0;
            checks++;
            if (k < 2 || k == 5) begin
                if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_latency cyc %0d got valid %b exp 0", k, out_valid); end
            end else begin
                if (out_valid !== 1'b1 || log_out !== exps[k - 2] || zero_flag !== 1'b0 || out_last !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL basic_out cyc %0d got v=%b log=%h z=%b l=%b exp v=1 log=%h z=0 l=0",
                             k, out_valid, log_out, zero_flag, out_last, exps[k - 2]);
                end
            end
        end
    endtask

    task automatic test_values();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mel_in    = 16'd3;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) mel_in = 16'd0;
            else        in_valid = 1'b0;
            if (k == 2) begin
                checks++;
                if (out_valid !== 1'b1 || log_out !== 16'h195C || zero_flag !== 1'b0) begin
                    errors++; $display("[TB] FAIL value_three got v=%b log=%h z=%b exp v=1 log=195C z=0", out_valid, log_out, zero_flag);
                end
            end
            if (k == 3) begin
                checks++;
                if (out_valid !== 1'b1 || log_out !== 16'h0000 || zero_flag !== 1'b1) begin
                    errors++; $display("[TB] FAIL value_zero got v=%b log=%h z=%b exp v=1 log=0000 z=1", out_valid, log_out, zero_flag);
                end
            end
        end
    endtask

    task automatic test_frame_last();
        exp_t e;
        int   sent = 0;
        int   n    = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            in_valid = (sent < 16);
            mel_in   = 16'($urandom_range(65535, 0) >> $urandom_range(15, 0));
            tick();
            if (obs_in_fire) sent++;
            if (obs_out_fire) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL frame_extra got %h exp none", obs_log); end
                else begin
                    e = exp_q.pop_front();
                    if ({obs_zero, obs_log} !== {e.zero, e.log} || obs_last !== (n == 7 || n == 15)) begin
                        errors++;
                        $display("[TB] FAIL frame_out #%0d got log=%h z=%b last=%b exp log=%h z=%b last=%b",
                                 n, obs_log, obs_zero, obs_last, e.log, e.zero, (n == 7 || n == 15));
                    end
                end
                n++;
            end
        end
        checks++; if (n != 16) begin errors++; $display("[TB] FAIL frame_count got %0d exp 16", n); end
    endtask

    task automatic test_stall();
        exp_t e;
        int   sent = 0;
        int   n    = 0;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mel_in = 16'($urandom_range(65535, 1));
            tick();
            if (obs_in_fire) sent++;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            mel_in = 16'($urandom_range(65535, 1));
            tick();
            if (obs_in_fire) sent++;
            checks++;
            if (obs_in_ready !== 1'b0 || obs_valid !== 1'b1 || exp_q.size() == 0 || obs_log !== exp_q[0].log) begin
                errors++;
                $display("[TB] FAIL stall_hold cyc %0d got rdy=%b v=%b log=%h exp rdy=0 v=1 log=%h",
                         c, obs_in_ready, obs_valid, obs_log, (exp_q.size() != 0) ? exp_q[0].log : 16'hxxxx);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            in_valid = (sent < 10);
            mel_in   = 16'($urandom_range(65535, 1));
            tick();
            if (obs_in_fire) sent++;
            if (obs_out_fire) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL stall_extra got %h exp none", obs_log); end
                else begin
                    e = exp_q.pop_front();
                    if (obs_log !== e.log) begin errors++; $display("[TB] FAIL stall_order #%0d got %h exp %h", n, obs_log, e.log); end
                end
                n++;
            end
        end
        checks++; if (n != 10 || sent != 10) begin errors++; $display("[TB] FAIL stall_count got %0d out %0d in exp 10 10", n, sent); end
    endtask

    task automatic test_random_stream();
        exp_t e;
        do_reset();
        for (int c = 0; c < 420; c++) begin
            in_valid  = (c < 400) ? ($urandom_range(99, 0) < 70) : 1'b0;
            out_ready = (c < 400) ? ($urandom_range(99, 0) < 70) : 1'b1;
            mel_in    = 16'($urandom_range(65535, 0) >> $urandom_range(16, 0));
            tick();
            checks++;
            if (obs_in_ready !== !(obs_valid && !obs_out_ready)) begin
                errors++; $display("[TB] FAIL rand_in_ready cyc %0d got %b exp %b", c, obs_in_ready, !(obs_valid && !obs_out_ready));
            end
            if (obs_out_fire) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL rand_extra got %h exp none", obs_log); end
                else begin
                    e = exp_q.pop_front();
                    if ({obs_zero, obs_log} !== {e.zero, e.log} || obs_last !== ((out_cnt % NF) == NF - 1)) begin
                        errors++;
                        $display("[TB] FAIL rand_out x=%h got log=%h z=%b last=%b exp log=%h z=%b last=%b",
                                 e.x, obs_log, obs_zero, obs_last, e.log, e.zero, ((out_cnt % NF) == NF - 1));
                    end
                end
                out_cnt++;
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL rand_drain got %0d pending exp 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        int   n    = 0;
        int   sent = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 20 && n < 3; c++) begin
            in_valid = 1'b1;
            mel_in   = 16'($urandom_range(65535, 1));
            tick();
            if (obs_out_fire) begin
                e = exp_q.pop_front();
                checks++;
                if (obs_log !== e.log || obs_last !== 1'b0) begin
                    errors++; $display("[TB] FAIL mid_pre #%0d got log=%h last=%b exp log=%h last=0", n, obs_log, obs_last, e.log);
                end
                n++;
            end
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid got %b exp 0", out_valid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        n = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (sent < 8);
            mel_in   = 16'($urandom_range(65535, 0) >> $urandom_range(15, 0));
            tick();
            if (obs_in_fire) sent++;
            if (obs_out_fire) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL mid_extra got %h exp none", obs_log); end
                else begin
                    e = exp_q.pop_front();
                    if ({obs_zero, obs_log} !== {e.zero, e.log} || obs_last !== (n == 7)) begin
                        errors++;
                        $display("[TB] FAIL mid_post #%0d got log=%h z=%b last=%b exp log=%h z=%b last=%b",
                                 n, obs_log, obs_zero, obs_last, e.log, e.zero, (n == 7));
                    end
                end
                n++;
            end
        end
        checks++; if (n != 8) begin errors++; $display("[TB] FAIL mid_count got %0d exp 8", n); end
    endtask

    task automatic test_accuracy();
        exp_t e;
        int   bnd [6] = '{1, 65535, 33791, 32768, 32767, 3};
        int   sent = 0;
        int   n    = 0;
`ifdef MEL_LOG_INTERP_EN
        real  err;
`endif
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 1120; c++) begin
            in_valid = (sent < 1100);
            mel_in   = (sent < 6) ? 16'(bnd[sent]) : 16'($urandom_range(65535, 1));
            tick();
            if (obs_in_fire) sent++;
            if (obs_out_fire) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL acc_extra got %h exp none", obs_log); end
                else begin
                    e = exp_q.pop_front();
                    if (obs_log !== e.log) begin errors++; $display("[TB] FAIL acc_exact x=%h got %h exp %h", e.x, obs_log, e.log); end
`ifdef MEL_LOG_INTERP_EN
                    err = real'(obs_log) / 4096.0 - $ln(real'(e.x)) / $ln(2.0);
                    if (err < 0.0) err = -err;
                    checks++;
                    if (err > 0.0015) begin errors++; $display("[TB] FAIL acc_bound x=%h got err %f exp <= 0.0015", e.x, err); end
`endif
                end
                n++;
            end
        end
        checks++; if (n != 1100) begin errors++; $display("[TB] FAIL acc_count got %0d exp 1100", n); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mel_in    = 16'd0;
        test_reset();
        test_basic();
        test_values();
        test_frame_last();
        test_stall();
        test_random_stream();
        test_reset_mid_frame();
        test_accuracy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
